// File: rtl/controlador_sessao_acesso_pkg.sv
// rtl/controlador_sessao_acesso_pkg.sv - shared state encoding and resource sizing
package controlador_sessao_acesso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_SESSION = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam int NUM_RES = 7;
    localparam int RES_W   = 3;

endpackage

// File: rtl/controlador_sessao_acesso_contador_tempo.sv
// rtl/controlador_sessao_acesso_contador_tempo.sv - clearable up-counter with terminal-count flag
module contador_tempo #(
    parameter int N = 16,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en)
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;
    assign tc    = (count_q == limit);

endmodule

// File: rtl/controlador_sessao_acesso.sv
// rtl/controlador_sessao_acesso.sv - login sequencer: decoder check, timed grant session, lockout
module controlador_sessao_acesso
    import controlador_sessao_acesso_pkg::*;
#(
    parameter int MAX_FAIL       = 3,
    parameter int SESSION_CYCLES = 16,
    parameter int LOCK_CYCLES    = 8,
    parameter int FAIL_W         = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               login_req,
    input  logic [2:0]         user_code,
    input  logic [RES_W-1:0]   res_sel,
    input  logic               logout,
    input  logic [NUM_RES-1:0] perm,
    output logic [2:0]         auth_code,
    output logic [NUM_RES-1:0] grant,
    output logic               access_ok,
    output logic               access_denied,
    output logic               locked,
    output logic [FAIL_W-1:0]  fail_count
);

    localparam int TMR_N = (SESSION_CYCLES > LOCK_CYCLES) ? SESSION_CYCLES : LOCK_CYCLES;
    localparam int TMR_W = (TMR_N > 1) ? $clog2(TMR_N) : 1;
    localparam logic [TMR_W-1:0] SESS_LAST = TMR_W'(SESSION_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_CYCLES - 1);

    state_t               state_q, state_d;
    logic [2:0]           auth_code_q, auth_code_d;
    logic [RES_W-1:0]     res_q, res_d;
    logic [NUM_RES-1:0]   grant_q, grant_d;
    logic                 ok_q, ok_d;
    logic                 den_q, den_d;
    logic                 locked_q, locked_d;
    logic [FAIL_W-1:0]    fail_q, fail_d;

    logic                 tmr_clr, tmr_en, tmr_tc;
    logic [TMR_W-1:0]     tmr_limit, tmr_count;
    logic [(1<<RES_W)-1:0] perm_ext;
    logic                 perm_hit, fail_last;

    // Index 7 maps onto a forced-zero bit so an out-of-range request always fails.
    always_comb begin
        perm_ext              = '0;
        perm_ext[NUM_RES-1:0] = perm;
    end

    assign perm_hit  = (int'(res_q) < NUM_RES) && perm_ext[res_q];
    assign fail_last = ((int'(fail_q) + 1) == MAX_FAIL);
    assign tmr_limit = (state_q == ST_LOCKED) ? LOCK_LAST : SESS_LAST;

    always_comb begin
        state_d     = state_q;
        auth_code_d = auth_code_q;
        res_d       = res_q;
        grant_d     = grant_q;
        ok_d        = 1'b0;
        den_d       = 1'b0;
        locked_d    = locked_q;
        fail_d      = fail_q;
        case (state_q)
            ST_IDLE: begin
                if (login_req) begin
                    auth_code_d = user_code;
                    res_d       = res_sel;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (perm_hit) begin
                    grant_d = NUM_RES'(1) << res_q;
                    ok_d    = 1'b1;
                    fail_d  = '0;
                    state_d = ST_SESSION;
                end else begin
                    den_d = 1'b1;
                    if (fail_last) begin
                        fail_d   = '0;
                        locked_d = 1'b1;
                        state_d  = ST_LOCKED;
                    end else begin
                        fail_d  = fail_q + FAIL_W'(1);
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SESSION: begin
                if (logout || tmr_tc) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (tmr_tc) begin
                    locked_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timer is zeroed on every state change, so it never runs past its limit.
    assign tmr_en  = (state_q == ST_SESSION) || (state_q == ST_LOCKED);
    assign tmr_clr = (state_d != state_q);

    contador_tempo #(.N(TMR_N)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_limit),
        .count (tmr_count),
        .tc    (tmr_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            auth_code_q <= '0;
            res_q       <= '0;
            grant_q     <= '0;
            ok_q        <= 1'b0;
            den_q       <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= '0;
        end else begin
            state_q     <= state_d;
            auth_code_q <= auth_code_d;
            res_q       <= res_d;
            grant_q     <= grant_d;
            ok_q        <= ok_d;
            den_q       <= den_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
        end
    end

    assign auth_code     = auth_code_q;
    assign grant         = grant_q;
    assign access_ok     = ok_q;
    assign access_denied = den_q;
    assign locked        = locked_q;
    assign fail_count    = fail_q;

endmodule

// File: tb/tb_controlador_sessao_acesso.sv
// tb/tb_controlador_sessao_acesso.sv - randomized and directed bench against a countdown reference model
module tb_controlador_sessao_acesso;

    localparam int MAX_FAIL = 3;
    localparam int SESS     = 16;
    localparam int LOCKC    = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       login_req = 1'b0;
    logic [2:0] user_code = '0;
    logic [2:0] res_sel = '0;
    logic       logout = 1'b0;
    logic [6:0] perm;
    logic [2:0] auth_code;
    logic [6:0] grant;
    logic       access_ok, access_denied, locked;
    logic [1:0] fail_count;

    int checks = 0;
    int errors = 0;

    // Reference: pending-check flag plus remaining-cycle countdowns.
    bit         m_pending;
    int         m_sess_left, m_lock_left, m_fail;
    logic [2:0] m_code, m_res;
    logic [6:0] m_grant;
    bit         m_ok, m_den, m_locked;

    always #5 clk = ~clk;

    function automatic logic [6:0] decode(input logic [2:0] c);
        logic a, b, cc;
        a = c[2]; b = c[1]; cc = c[0];
        return {a | b, b & cc, a & ~b, ~a | cc, cc, a ^ b, a & b & cc};
    endfunction

    assign perm = decode(auth_code);

    controlador_sessao_acesso dut (
        .clk(clk), .rst(rst), .login_req(login_req), .user_code(user_code),
        .res_sel(res_sel), .logout(logout), .perm(perm), .auth_code(auth_code),
        .grant(grant), .access_ok(access_ok), .access_denied(access_denied),
        .locked(locked), .fail_count(fail_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending = 0; m_sess_left = 0; m_lock_left = 0; m_fail = 0;
        m_code = '0; m_res = '0; m_grant = '0; m_ok = 0; m_den = 0; m_locked = 0;
    endtask

    task automatic model_edge();
        logic [6:0] p;
        m_ok = 0; m_den = 0;
        if (m_pending) begin
            m_pending = 0;
            p = decode(m_code);
            if (m_res != 3'd7 && p[m_res]) begin
                m_grant = 7'(1 << m_res); m_sess_left = SESS; m_fail = 0; m_ok = 1;
            end else begin
                m_den = 1;
                if (m_fail + 1 == MAX_FAIL) begin
                    m_fail = 0; m_lock_left = LOCKC; m_locked = 1;
                end else begin
                    m_fail++;
                end
            end
        end else if (m_sess_left > 0) begin
            if (logout || m_sess_left == 1) begin
                m_grant = '0; m_sess_left = 0;
            end else begin
                m_sess_left--;
            end
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_locked = 0;
        end else if (login_req) begin
            m_code = user_code; m_res = res_sel; m_pending = 1;
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".grant"}, 32'(grant), 32'(m_grant));
        check_val({tag, ".ok"}, 32'(access_ok), 32'(m_ok));
        check_val({tag, ".den"}, 32'(access_denied), 32'(m_den));
        check_val({tag, ".locked"}, 32'(locked), 32'(m_locked));
        check_val({tag, ".fail"}, 32'(fail_count), 32'(m_fail));
        check_val({tag, ".code"}, 32'(auth_code), 32'(m_code));
        check_val({tag, ".excl"}, 32'(access_ok & access_denied), 32'd0);
    endtask

    task automatic step(input logic lr, input logic [2:0] uc, input logic [2:0] rs, input logic lo, input string tag);
        login_req = lr; user_code = uc; res_sel = rs; logout = lo;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 3'd0, 1'b0, tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check_val({tag, ".grant"}, 32'(grant), 32'd0);
        check_val({tag, ".locked"}, 32'(locked), 32'd0);
        check_val({tag, ".fail"}, 32'(fail_count), 32'd0);
        check_val({tag, ".code"}, 32'(auth_code), 32'd0);
        model_reset();
        @(negedge clk);
        login_req = 1'b0; logout = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // Success on resource 4, full-length session.
        step(1'b1, 3'b100, 3'd4, 1'b0, "ok_login");
        step(1'b0, 3'b000, 3'd0, 1'b0, "ok_check");
        check_val("ok_pulse", 32'(access_ok), 32'd1);
        check_val("ok_grant", 32'(grant), 32'h10);
        idle(SESS + 2, "ok_sess");

        // Logout on third session cycle.
        step(1'b1, 3'b011, 3'd1, 1'b0, "lo_login");
        idle(3, "lo_sess");
        check_val("lo_grant", 32'(grant), 32'h02);
        step(1'b0, 3'b000, 3'd0, 1'b1, "lo_exit");
        check_val("lo_cleared", 32'(grant), 32'd0);

        // Three denials into lockout; login held during lockout.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 3'b000, 3'd2, 1'b0, "den_login");
            step(1'b0, 3'b000, 3'd0, 1'b0, "den_check");
            check_val("den_pulse", 32'(access_denied), 32'd1);
        end
        check_val("lock_on", 32'(locked), 32'd1);
        for (int k = 0; k < LOCKC + 1; k++) step(1'b1, 3'b100, 3'd4, 1'b0, "lock_hold");
        idle(SESS + 3, "lock_after");

        // Two denials then success clears fail_count.
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 3'b000, 3'd2, 1'b0, "rec_den");
            idle(1, "rec_den_chk");
        end
        step(1'b1, 3'b001, 3'd3, 1'b0, "rec_login");
        idle(1, "rec_chk");
        check_val("rec_fail0", 32'(fail_count), 32'd0);
        step(1'b0, 3'b000, 3'd0, 1'b1, "rec_exit");

        // Out-of-range resource.
        step(1'b1, 3'b111, 3'd7, 1'b0, "r7_login");
        idle(2, "r7_chk");

        // Async reset mid-session and mid-lockout.
        step(1'b1, 3'b100, 3'd4, 1'b0, "rs_login");
        idle(5, "rs_sess");
        async_reset("rst_sess");
        idle(1, "rst_sess_post");
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 3'b000, 3'd2, 1'b0, "rl_login");
            idle(1, "rl_chk");
        end
        idle(3, "rl_lock");
        async_reset("rst_lock");
        step(1'b1, 3'b100, 3'd4, 1'b0, "post_login");
        idle(3, "post_chk");
        step(1'b0, 3'b000, 3'd0, 1'b1, "post_exit");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 2) == 0), 3'($urandom), 3'($urandom),
                 1'($urandom_range(0, 7) == 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
